// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Operand/result bundle for the bit-serial subtractor.
//   master: requester side. It drives start, a, b and borrow_in, and it
//           observes ready, busy, done, diff and borrow_out.
//   slave : subtractor side. It takes the opposite directions.
//   WIDTH : operand and result width. It must match the attached subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b, borrow_in,
        input  ready, busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b, borrow_in,
        output ready, busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor. It computes a - b - borrow_in one bit per
//   clock, least significant bit first. It uses one full-subtractor cell and
//   one borrow flip-flop.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_subtractor_if
//           start/ready form the accept handshake (a, b and borrow_in are
//           sampled on accept). busy is high during the serial run. done
//           pulses for one cycle. diff and borrow_out are registered and are
//           held until the next operation completes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    // Full-subtractor cell: difference bit.
    function automatic logic fs_diff(input logic x, input logic y, input logic bin);
        return x ^ y ^ bin;
    endfunction

    // Full-subtractor cell: borrow out.
    function automatic logic fs_borrow(input logic x, input logic y, input logic bin);
        return (~x & y) | (~(x ^ y) & bin);
    endfunction

    logic             d_bit;
    logic             b_bit;
    logic [WIDTH-1:0] sd_next;

    always_comb begin
        d_bit   = fs_diff(sa[0], sb[0], br);
        b_bit   = fs_borrow(sa[0], sb[0], br);
        // The new difference bit enters at the MSB. After WIDTH shifts, the
        // bit processed first has reached bit 0. The shift/or form also covers
        // WIDTH=1 without a degenerate slice.
        sd_next = (sd >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sa       <= '0;
            sb       <= '0;
            sd       <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // ready is 1 throughout IDLE, so start alone marks an accept.
                    if (bus.start) begin
                        sa    <= bus.a;
                        sb    <= bus.b;
                        br    <= bus.borrow_in;
                        sd    <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sd  <= sd_next;
                    br  <= b_bit;
                    cnt <= cnt + 1'b1;
                    // The last bit is processed here. Publish the result on
                    // the same edge.
                    if (cnt == LAST) begin
                        diff_q   <= sd_next;
                        borrow_q <= b_bit;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status outputs decode registered state only, so no input reaches an
    // output combinationally.
    assign bus.ready      = (state == IDLE);
    assign bus.busy       = (state == RUN);
    assign bus.done       = (state == DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Bench for serial_subtractor at WIDTH = 1, 8 and 13.
//   A behavioural reference model produces every expected result.
module tb_serial_subtractor;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(1))  i1 ();
    serial_subtractor_if #(.WIDTH(8))  i8 ();
    serial_subtractor_if #(.WIDTH(13)) i13 ();

    serial_subtractor #(.WIDTH(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
    serial_subtractor #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
    serial_subtractor #(.WIDTH(13)) u13 (.clk(clk), .rst_n(rst_n), .bus(i13.slave));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer subtraction. It returns {borrow, diff}.
    function automatic logic [13:0] ref_sub(input int w, input logic [12:0] a,
                                            input logic [12:0] b, input logic bi);
        longint r;
        longint m;
        logic   bo;
        m  = (longint'(1) << w) - 1;
        r  = longint'(a) - longint'(b) - longint'(bi);
        bo = longint'(a) < (longint'(b) + longint'(bi));
        return {bo, 13'(r & m)};
    endfunction

    task automatic set_in(input int sel, input logic st, input logic [12:0] a,
                          input logic [12:0] b, input logic bi);
        case (sel)
            1:       begin i1.start  = st; i1.a  = a[0];    i1.b  = b[0];    i1.borrow_in  = bi; end
            8:       begin i8.start  = st; i8.a  = a[7:0];  i8.b  = b[7:0];  i8.borrow_in  = bi; end
            default: begin i13.start = st; i13.a = a;       i13.b = b;       i13.borrow_in = bi; end
        endcase
    endtask

    function automatic logic get_ready(input int sel);
        case (sel)
            1: return i1.ready;
            8: return i8.ready;
            default: return i13.ready;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            1: return i1.busy;
            8: return i8.busy;
            default: return i13.busy;
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            1: return i1.done;
            8: return i8.done;
            default: return i13.done;
        endcase
    endfunction

    function automatic logic [13:0] get_res(input int sel);
        case (sel)
            1: return {i1.borrow_out, 12'b0, i1.diff};
            8: return {i8.borrow_out, 5'b0, i8.diff};
            default: return {i13.borrow_out, i13.diff};
        endcase
    endfunction

    // One complete operation. The task is entered and left just after a
    // falling edge.
    task automatic op(input int sel, input int w, input logic [12:0] a,
                      input logic [12:0] b, input logic bi, input string tag);
        logic [13:0] exp;
        logic [13:0] held;
        int          lat;
        exp  = ref_sub(w, a, b, bi);
        held = get_res(sel);
        check({tag, " ready_before"}, 32'(get_ready(sel)), 32'd1);
        set_in(sel, 1'b1, a, b, bi);
        @(negedge clk);
        // The operands are now latched. Scramble the inputs so that any late
        // sampling would corrupt the result.
        set_in(sel, 1'b0, 13'($urandom), 13'($urandom), 1'($urandom));
        check({tag, " busy"}, 32'(get_busy(sel)), 32'd1);
        lat = 0;
        while (!get_done(sel) && lat < w + 5) begin
            check({tag, " hold"}, 32'(get_res(sel)), 32'(held));
            check({tag, " ready_run"}, 32'(get_ready(sel)), 32'd0);
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(w));
        check({tag, " result"}, 32'(get_res(sel)), 32'(exp));
        check({tag, " ready_done"}, 32'(get_ready(sel)), 32'd0);
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(get_done(sel)), 32'd0);
        check({tag, " ready_after"}, 32'(get_ready(sel)), 32'd1);
        check({tag, " result_kept"}, 32'(get_res(sel)), 32'(exp));
    endtask

    initial begin
        logic [12:0] qa[$];
        logic [12:0] qb[$];
        logic        qbi[$];
        logic [12:0] va;
        logic [12:0] vb;
        logic        vbi;
        logic [13:0] exp;
        int          cyc;
        int          last_acc;
        int          nacc;

        set_in(1, 1'b0, 13'd0, 13'd0, 1'b0);
        set_in(8, 1'b0, 13'd0, 13'd0, 1'b0);
        set_in(13, 1'b0, 13'd0, 13'd0, 1'b0);

        // Reset state.
        #1;
        check("rst ready", 32'(i8.ready), 32'd1);
        check("rst busy", 32'(i8.busy), 32'd0);
        check("rst done", 32'(i8.done), 32'd0);
        check("rst result", 32'(get_res(8)), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases at WIDTH=8.
        op(8, 8, 13'h5A, 13'h23, 1'b0, "w8_5a_23");
        op(8, 8, 13'h00, 13'h01, 1'b0, "w8_00_01");
        op(8, 8, 13'h80, 13'h7F, 1'b1, "w8_80_7f_b");
        op(8, 8, 13'h00, 13'hFF, 1'b1, "w8_00_ff_b");

        // WIDTH=1: exhaustive full-subtractor truth table.
        for (int k = 0; k < 8; k++) begin
            op(1, 1, 13'(k & 1), 13'((k >> 1) & 1), 1'((k >> 2) & 1), "w1_tt");
        end

        // start held high while the operands change every cycle.
        cyc      = 0;
        last_acc = -1;
        nacc     = 0;
        for (int t = 0; t < 80; t++) begin
            va  = 13'($urandom) & 13'hFF;
            vb  = 13'($urandom) & 13'hFF;
            vbi = 1'($urandom);
            set_in(8, (t < 55), va, vb, vbi);
            if (i8.done) begin
                if (qa.size() > 0) begin
                    exp = ref_sub(8, qa.pop_front(), qb.pop_front(), qbi.pop_front());
                    check("held_start result", 32'(get_res(8)), 32'(exp));
                end else begin
                    check("held_start unexpected_done", 32'd1, 32'd0);
                end
            end
            if (i8.start && i8.ready) begin
                qa.push_back(va);
                qb.push_back(vb);
                qbi.push_back(vbi);
                if (last_acc >= 0) check("held_start gap", 32'(cyc - last_acc), 32'd10);
                last_acc = cyc;
                nacc++;
            end
            @(negedge clk);
            cyc++;
        end
        check("held_start drained", 32'(qa.size()), 32'd0);
        check("held_start accepts", 32'(nacc >= 5), 32'd1);

        // Reset three cycles into RUN.
        set_in(8, 1'b1, 13'h5A, 13'h23, 1'b0);
        @(negedge clk);
        set_in(8, 1'b0, 13'h0, 13'h0, 1'b0);
        repeat (3) @(negedge clk);
        check("abort busy_before", 32'(i8.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort ready", 32'(i8.ready), 32'd1);
        check("abort busy", 32'(i8.busy), 32'd0);
        check("abort result", 32'(get_res(8)), 32'd0);
        @(negedge clk);
        check("abort no_done", 32'(i8.done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort no_done_after", 32'(i8.done), 32'd0);
        op(8, 8, 13'h10, 13'h01, 1'b0, "w8_after_abort");

        // Random vectors at WIDTH=8 and WIDTH=13.
        for (int n = 0; n < 1200; n++) begin
            op(8, 8, 13'($urandom) & 13'hFF, 13'($urandom) & 13'hFF, 1'($urandom), "w8_rand");
        end
        for (int n = 0; n < 800; n++) begin
            op(13, 13, 13'($urandom), 13'($urandom), 1'($urandom), "w13_rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
